// File: rtl/riscv_cfi_decrypt_seq_if.sv
// Fetch-side handshake bundle for the CFI decrypt sequencer.
// slave: the decrypt block; master: the fetch unit / consumer pair driving it.
interface riscv_cfi_decrypt_seq_if #(
  parameter int unsigned CFI_TAG_WIDTH = 160
) ();
  logic                     flush_i;
  logic                     cfi_en_i;
  logic [CFI_TAG_WIDTH-1:0] cfi_tag_i;
  logic                     in_valid_i;
  logic                     in_ready_o;
  logic [31:0]              in_rdata_i;
  logic [31:0]              in_addr_i;
  logic                     out_valid_o;
  logic                     out_ready_i;
  logic [31:0]              out_rdata_o;
  logic [31:0]              out_addr_o;
  logic                     busy_o;

  modport slave (
    input  flush_i, cfi_en_i, cfi_tag_i, in_valid_i, in_rdata_i, in_addr_i, out_ready_i,
    output in_ready_o, out_valid_o, out_rdata_o, out_addr_o, busy_o
  );

  modport master (
    output flush_i, cfi_en_i, cfi_tag_i, in_valid_i, in_rdata_i, in_addr_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_rdata_o, out_addr_o, busy_o
  );
endinterface

// File: rtl/riscv_cfi_decrypt_seq.sv
// Single-word fetch decrypt sequencer: accepts one fetched word, optionally XORs it
// with a keystream word derived over ROUNDS cycles from the fetch address and CFI tag,
// then holds the plaintext until the consumer takes it.
module riscv_cfi_decrypt_seq #(
  parameter int unsigned CFI_TAG_WIDTH = 160,
  parameter int unsigned ROUNDS        = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  riscv_cfi_decrypt_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  localparam logic [3:0] LastCnt = 4'(ROUNDS - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] s_q;
  logic [31:0] rdata_q;
  logic [31:0] addr_q;
  logic        mode_q;

  logic        accept;
  logic [31:0] s_next;

  // Only the low 64 tag bits carry key material.
  if (CFI_TAG_WIDTH > 64) begin : g_tag_hi
    logic unused_tag_hi;
    assign unused_tag_hi = ^bus.cfi_tag_i[CFI_TAG_WIDTH-1:64];
  end

  assign bus.in_ready_o  = (state_q == StIdle) & ~bus.flush_i;
  assign accept          = bus.in_valid_i & bus.in_ready_o;
  assign bus.out_valid_o = (state_q == StHold);
  assign bus.busy_o      = (state_q != StIdle);
  assign bus.out_rdata_o = rdata_q;
  assign bus.out_addr_o  = addr_q;

  // One keystream round; the tag is read live, the driver keeps it stable while busy.
  assign s_next = {s_q[26:0], s_q[31:27]} ^ bus.cfi_tag_i[63:32] ^ {28'd0, cnt_q};

  // Sequencer FSM and datapath registers; flush overrides every other event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      s_q     <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      mode_q  <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rdata_q <= bus.in_rdata_i;
            addr_q  <= bus.in_addr_i;
            mode_q  <= bus.cfi_en_i;
            cnt_q   <= '0;
            s_q     <= bus.in_addr_i ^ bus.cfi_tag_i[31:0];
            state_q <= bus.cfi_en_i ? StCalc : StHold;
          end
        end
        StCalc: begin
          s_q   <= s_next;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LastCnt) begin
            // Only the mode latched at accept decides whether the word is decrypted.
            if (mode_q) rdata_q <= rdata_q ^ s_next;
            state_q <= StHold;
          end
        end
        StHold: begin
          if (bus.out_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_cfi_decrypt_seq.sv
// Directed bench for riscv_cfi_decrypt_seq: bypass, decrypt, backpressure, flush, reset.
module tb_riscv_cfi_decrypt_seq;

  localparam int unsigned TagW   = 160;
  localparam int unsigned Rounds = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  riscv_cfi_decrypt_seq_if #(.CFI_TAG_WIDTH(TagW)) bus ();

  riscv_cfi_decrypt_seq #(
    .CFI_TAG_WIDTH(TagW),
    .ROUNDS       (Rounds)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic en, input logic [31:0] data, input logic [31:0] addr);
    bus.in_valid_i = 1'b1;
    bus.cfi_en_i   = en;
    bus.in_rdata_i = data;
    bus.in_addr_i  = addr;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n           = 1'b0;
    bus.flush_i     = 1'b0;
    bus.cfi_en_i    = 1'b0;
    bus.cfi_tag_i   = '0;
    bus.in_valid_i  = 1'b0;
    bus.in_rdata_i  = '0;
    bus.in_addr_i   = '0;
    bus.out_ready_i = 1'b0;
    #1;
    // Reset state
    check("rst_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_busy", 64'(bus.busy_o), 64'd0);
    check("rst_rdata", 64'(bus.out_rdata_o), 64'd0);
    check("rst_addr", 64'(bus.out_addr_o), 64'd0);
    check("rst_ready", 64'(bus.in_ready_o), 64'd1);
    bus.flush_i = 1'b1;
    #1;
    check("rst_ready_flush", 64'(bus.in_ready_o), 64'd0);
    bus.flush_i = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Bypass: one-cycle latency, data unchanged
    offer(1'b0, 32'h0000_0013, 32'h0000_0100);
    check("byp_ready", 64'(bus.in_ready_o), 64'd1);
    tick();
    bus.in_valid_i = 1'b0;
    check("byp_valid", 64'(bus.out_valid_o), 64'd1);
    check("byp_rdata", 64'(bus.out_rdata_o), 64'h13);
    check("byp_addr", 64'(bus.out_addr_o), 64'h100);
    check("byp_hold_ready", 64'(bus.in_ready_o), 64'd0);
    // Drain; a word offered in the drain cycle must not be taken
    bus.out_ready_i = 1'b1;
    offer(1'b0, 32'h1111_2222, 32'h0000_0104);
    tick();
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b0;
    check("drain_valid", 64'(bus.out_valid_o), 64'd0);
    check("drain_busy", 64'(bus.busy_o), 64'd0);
    tick();
    check("drain_no_accept", 64'(bus.busy_o), 64'd0);

    // Decrypt with zero tag; cfi_en drops right after accept (mode latch)
    bus.cfi_tag_i = '0;
    offer(1'b1, 32'h0000_0013, 32'h0000_0000);
    tick();
    bus.in_valid_i = 1'b0;
    bus.cfi_en_i   = 1'b0;
    check("dec_t1_valid", 64'(bus.out_valid_o), 64'd0);
    check("dec_t1_busy", 64'(bus.busy_o), 64'd1);
    tick();
    tick();
    tick();
    check("dec_t4_valid", 64'(bus.out_valid_o), 64'd0);
    tick();
    check("dec_t5_valid", 64'(bus.out_valid_o), 64'd1);
    check("dec_t5_rdata", 64'(bus.out_rdata_o), 64'h450);
    check("dec_t5_addr", 64'(bus.out_addr_o), 64'h0);

    // Backpressure: 10 cycles with out_ready low, everything stays put
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold", {30'd0, bus.out_valid_o, bus.in_ready_o, bus.out_rdata_o},
            {30'd0, 1'b1, 1'b0, 32'h0000_0450});
    end
    bus.in_valid_i  = 1'b0;
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    check("bp_release_busy", 64'(bus.busy_o), 64'd0);

    // Decrypt with a nonzero tag and address
    bus.cfi_tag_i = '0;
    bus.cfi_tag_i[63:0] = 64'h8000_0000_0000_0001;
    offer(1'b1, 32'hDEAD_BEEF, 32'h0000_0004);
    tick();
    bus.in_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("tag_valid", 64'(bus.out_valid_o), 64'd1);
    check("tag_rdata", 64'(bus.out_rdata_o), 64'h5EFD_F8BC);
    check("tag_addr", 64'(bus.out_addr_o), 64'h4);
    bus.out_ready_i = 1'b1;
    tick();
    bus.out_ready_i = 1'b0;
    bus.cfi_tag_i   = '0;

    // Flush in CALC at cnt==2
    offer(1'b1, 32'h0000_0013, 32'h0000_0000);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    tick();
    bus.flush_i    = 1'b1;
    bus.in_valid_i = 1'b1;
    #1;
    check("fl_calc_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    bus.flush_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    check("fl_calc_busy", 64'(bus.busy_o), 64'd0);
    for (int i = 0; i < 4; i++) tick();
    check("fl_calc_no_out", 64'(bus.out_valid_o), 64'd0);

    // Flush in HOLD together with out_ready
    offer(1'b0, 32'h0000_00AA, 32'h0000_0300);
    tick();
    bus.in_valid_i = 1'b0;
    check("fl_hold_pre", 64'(bus.out_valid_o), 64'd1);
    bus.flush_i     = 1'b1;
    bus.out_ready_i = 1'b1;
    bus.in_valid_i  = 1'b1;
    #1;
    check("fl_hold_ready", 64'(bus.in_ready_o), 64'd0);
    tick();
    bus.flush_i     = 1'b0;
    bus.out_ready_i = 1'b0;
    bus.in_valid_i  = 1'b0;
    check("fl_hold_valid", 64'(bus.out_valid_o), 64'd0);
    check("fl_hold_busy", 64'(bus.busy_o), 64'd0);

    // Reset mid-CALC, then bypass completes with one-cycle latency
    offer(1'b1, 32'h0000_0013, 32'h0000_0000);
    tick();
    bus.in_valid_i = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("rst_calc_valid", 64'(bus.out_valid_o), 64'd0);
    check("rst_calc_busy", 64'(bus.busy_o), 64'd0);
    check("rst_calc_rdata", 64'(bus.out_rdata_o), 64'd0);
    tick();
    rst_n = 1'b1;
    offer(1'b0, 32'hABCD_0001, 32'h0000_0200);
    tick();
    bus.in_valid_i = 1'b0;
    check("post_rst_valid", 64'(bus.out_valid_o), 64'd1);
    check("post_rst_rdata", 64'(bus.out_rdata_o), 64'hABCD_0001);
    check("post_rst_addr", 64'(bus.out_addr_o), 64'h200);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_cfi_decrypt_seq.md
RISCV_CFI_DECRYPT_SEQ -- requirements
Module: riscv_cfi_decrypt_seq

Interface
REQ-001 The block SHALL have parameter CFI_TAG_WIDTH, default 160, giving the CFI tag width; legal values are 64 and above.
REQ-002 The block SHALL have parameter ROUNDS, default 4, giving the number of keystream rounds; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port flush_i, input, 1 bit: discard the word in flight (branch or pc_set).
REQ-006 The block SHALL have port cfi_en_i, input, 1 bit: decryption enable, sampled at accept.
REQ-007 The block SHALL have port cfi_tag_i, input, CFI_TAG_WIDTH bits: key material; only bits [63:0] are used.
REQ-008 The block SHALL have port in_valid_i, input, 1 bit: a fetched word is offered.
REQ-009 The block SHALL have port in_ready_o, output, 1 bit: the block can accept a word.
REQ-010 The block SHALL have port in_rdata_i, input, 32 bits: fetched (possibly encrypted) word.
REQ-011 The block SHALL have port in_addr_i, input, 32 bits: fetch address of in_rdata_i.
REQ-012 The block SHALL have port out_valid_o, output, 1 bit: the plaintext word is valid.
REQ-013 The block SHALL have port out_ready_i, input, 1 bit: the consumer takes the word.
REQ-014 The block SHALL have port out_rdata_o, output, 32 bits: plaintext word.
REQ-015 The block SHALL have port out_addr_o, output, 32 bits: address of out_rdata_o.
REQ-016 The block SHALL have port busy_o, output, 1 bit: the state is not IDLE.

Function
REQ-017 The block SHALL implement an FSM with exactly the states IDLE, CALC and HOLD.
REQ-018 in_ready_o SHALL equal (state==IDLE) & ~flush_i, combinationally.
REQ-019 Accept SHALL occur in any cycle where in_valid_i & in_ready_o; on that edge the block SHALL register in_rdata_i, in_addr_i and cfi_en_i.
REQ-020 On accept with cfi_en_i=0 (bypass), the next state SHALL be HOLD, and out_rdata_o SHALL equal in_rdata_i unchanged.
REQ-021 On accept with cfi_en_i=1, the next state SHALL be CALC, with round counter cnt=0 and key state s = in_addr_i ^ cfi_tag_i[31:0].
REQ-022 On each CALC edge, the block SHALL update s <= rotl(s,5) ^ cfi_tag_i[63:32] ^ zero-extend(cnt), and increment cnt; when cnt==ROUNDS-1 on that edge, the next state SHALL be HOLD.
REQ-023 On entry to HOLD from CALC, out_rdata_o SHALL equal the registered word XOR the final s; all arithmetic is 32-bit modulo and cnt is 4 bits.
REQ-024 out_valid_o SHALL equal (state==HOLD); out_rdata_o and out_addr_o SHALL be stable while out_valid_o=1.
REQ-025 Latency: with an accept in cycle t, out_valid_o SHALL first rise in cycle t+1 in bypass and in cycle t+1+ROUNDS when enabled.
REQ-026 In HOLD with out_ready_i=1, the next state SHALL be IDLE; the block SHALL NOT accept a new word in that same cycle (maximum one word per 2 cycles in bypass).
REQ-027 flush_i SHALL have priority over every other event: from any state the next state is IDLE, no accept occurs, and the pending word is dropped even if out_ready_i=1.
REQ-028 A change of cfi_en_i or cfi_tag_i after accept SHALL NOT affect the word's mode, but cfi_tag_i SHALL be read live during CALC; the driver holds the tag stable while busy_o=1.
REQ-029 busy_o SHALL equal (state!=IDLE).

Reset
REQ-030 rst_n=0 SHALL asynchronously force state=IDLE, cnt=0, s=0, with data registers at 0 and the registered mode at 0.
REQ-031 During reset: out_valid_o=0, busy_o=0, out_rdata_o=0, out_addr_o=0, and in_ready_o=~flush_i.
REQ-032 Reset asserted mid-CALC or mid-HOLD SHALL discard the word; the first accept after release behaves as from power-on.

Verification
REQ-033 Bypass: cfi_en_i=0, in_rdata_i=0x00000013 and in_addr_i=0x100 accepted in cycle t -> out_valid_o=1 in cycle t+1 with out_rdata_o=0x00000013 and out_addr_o=0x100.
REQ-034 Decrypt: ROUNDS=4, tag[63:0]=0, addr=0, in_rdata_i=0x00000013, cfi_en_i=1 -> out_valid_o first high in cycle t+5 with out_rdata_o=0x00000450.
REQ-035 Backpressure: hold out_ready_i=0 for 10 cycles in HOLD -> out_valid_o and the data stay constant and in_ready_o stays 0; on out_ready_i=1 -> IDLE on the next cycle.
REQ-036 Flush: assert flush_i at cnt=2 in CALC, and separately in HOLD together with out_ready_i=1 -> IDLE on the next cycle with no output transfer, and in_ready_o=0 during the flush cycle.
REQ-037 Reset: pull rst_n low mid-CALC -> out_valid_o=0 and busy_o=0 immediately; after release, a bypass word completes with 1-cycle latency.
REQ-038 Mode latch: cfi_en_i toggles 1->0 on the cycle after accept -> the word is still decrypted (REQ-034 value).
